// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants and helpers for the ring-buffer FIFO:
//                read-mode selectors, count/pointer width helpers and the
//                pointer-increment-with-wrap function.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Read-mode selectors for the SHOW_AHEAD parameter
    localparam int RD_REGISTERED = 0;
    localparam int RD_SHOW_AHEAD = 1;

    // Bits needed to hold an occupancy of 0..depth inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to address depth entries (at least one bit)
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Advance a pointer, wrapping by explicit compare so non-power-of-two
    // depths never visit unused addresses
    function automatic int ptr_next(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ring_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ring_if
//  Description : Producer/consumer bundle of the ring-buffer FIFO. The
//                master modport is the user side, the slave modport the FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_ring_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = cnt_width(8)
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_val;
    logic [CNT_W-1:0]      count;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  wr_ready, rd_data, rd_val, count,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output wr_ready, rd_data, rd_val, count,
               almost_full, almost_empty, overflow, underflow
    );

endinterface : fifo_ring_if
`default_nettype wire

// File: rtl/fifo_ring_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ring_mem
//  Description : FIFO_DEPTH x DATA_WIDTH simple dual-port storage with one
//                synchronous write port and an asynchronous read address.
//                Contents are intentionally not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ring_mem
    import fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = ptr_width(FIFO_DEPTH)
) (
    input  wire logic                  clk,
    input  wire logic                  wr_en,
    input  wire logic [ADDR_W-1:0]     wr_addr,
    input  wire logic [DATA_WIDTH-1:0] wr_data,
    input  wire logic [ADDR_W-1:0]     rd_addr,
    output logic      [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    // Write port: store the word at the write address on an accepted write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : fifo_ring_mem
`default_nettype wire

// File: rtl/fifo_ring.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ring
//  Description : Single-clock circular-buffer FIFO with occupancy count,
//                programmable almost-full/almost-empty flags, registered
//                overflow/underflow pulses and a selectable registered or
//                show-ahead (first-word-fall-through) read mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ring
    import fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int SHOW_AHEAD = RD_REGISTERED,
    parameter int CNT_W      = cnt_width(FIFO_DEPTH)
) (
    input wire logic   clk,
    input wire logic   reset,
    fifo_ring_if.slave bus
);

    localparam int               PTR_W       = ptr_width(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_depth     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_af_level  = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] c_ae_level  = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    // Elaboration-time parameter range checks
    if (FIFO_DEPTH < 2) begin : g_chk_depth
        $error("fifo_ring: FIFO_DEPTH must be >= 2");
    end
    if (DATA_WIDTH < 1) begin : g_chk_width
        $error("fifo_ring: DATA_WIDTH must be >= 1");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_chk_af
        $error("fifo_ring: AF_LEVEL out of range 1..FIFO_DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_chk_ae
        $error("fifo_ring: AE_LEVEL out of range 0..FIFO_DEPTH-1");
    end
    if (SHOW_AHEAD != RD_REGISTERED && SHOW_AHEAD != RD_SHOW_AHEAD) begin : g_chk_mode
        $error("fifo_ring: SHOW_AHEAD must be 0 or 1");
    end
    if (CNT_W != cnt_width(FIFO_DEPTH)) begin : g_chk_cnt_w
        $error("fifo_ring: CNT_W is derived from FIFO_DEPTH and must not be overridden");
    end

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_acc_wr;
    logic                  w_acc_rd;
    logic [DATA_WIDTH-1:0] w_mem_rd_data;

    assign w_full   = (r_count == c_depth);
    assign w_empty  = (r_count == '0);
    // A same-cycle read never makes room for a write when full, and a
    // same-cycle write never satisfies a read when empty.
    assign w_acc_wr = bus.wr_en && !w_full;
    assign w_acc_rd = bus.rd_en && !w_empty;

    fifo_ring_mem #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_acc_wr),
        .wr_addr (r_wr_ptr),
        .wr_data (bus.wr_data),
        .rd_addr (r_rd_ptr),
        .rd_data (w_mem_rd_data)
    );

    // Pointer, occupancy and error-pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= bus.wr_en && w_full;
            r_underflow <= bus.rd_en && w_empty;
            if (w_acc_wr) begin
                r_wr_ptr <= PTR_W'(ptr_next(int'(r_wr_ptr), FIFO_DEPTH));
            end
            if (w_acc_rd) begin
                r_rd_ptr <= PTR_W'(ptr_next(int'(r_rd_ptr), FIFO_DEPTH));
            end
            if (w_acc_wr && !w_acc_rd) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_acc_wr && w_acc_rd) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    assign bus.count        = r_count;
    assign bus.wr_ready     = !w_full;
    assign bus.almost_full  = (r_count >= c_af_level);
    assign bus.almost_empty = (r_count <= c_ae_level);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

    if (SHOW_AHEAD == RD_SHOW_AHEAD) begin : g_show_ahead
        // Head word is presented directly; valid whenever anything is stored
        assign bus.rd_data = w_mem_rd_data;
        assign bus.rd_val  = !w_empty;
    end else begin : g_registered
        logic [DATA_WIDTH-1:0] r_rd_data;
        logic                  r_rd_val;

        // Capture the head word on an accepted read; rd_val pulses one cycle
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_rd_data <= '0;
                r_rd_val  <= 1'b0;
            end else begin
                r_rd_val <= w_acc_rd;
                if (w_acc_rd) begin
                    r_rd_data <= w_mem_rd_data;
                end
            end
        end

        assign bus.rd_data = r_rd_data;
        assign bus.rd_val  = r_rd_val;
    end

endmodule : fifo_ring
`default_nettype wire

// File: doc/fifo_ring.md
# fifo_ring

Synchronous single-clock FIFO that succeeds the shift-register FIFO. Storage is a circular buffer with wrapping read and write pointers, so no data moves between entries. The block adds an occupancy count, programmable almost-full and almost-empty flags, overflow and underflow pulses, and a selectable show-ahead (first-word-fall-through) read mode. It is the standard buffering element between producer and consumer pipelines in the design.

## Interface
- `FIFO_DEPTH`, default 8: number of entries, ≥ 2; non-power-of-two values are supported.
- `DATA_WIDTH`, default 8: word width, ≥ 1.
- `AF_LEVEL`, default `FIFO_DEPTH-1`: `almost_full` asserts when count ≥ `AF_LEVEL`; range 1..`FIFO_DEPTH`.
- `AE_LEVEL`, default 1: `almost_empty` asserts when count ≤ `AE_LEVEL`; range 0..`FIFO_DEPTH-1`.
- `SHOW_AHEAD`, default 0: selects the read mode; 0 = registered read, 1 = first-word-fall-through.
- `CNT_W`, default `$clog2(FIFO_DEPTH+1)`: width of the count; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write request.
- `wr_data`  in  `DATA_WIDTH`  write word.
- `wr_ready`  out  1  FIFO not full (count < `FIFO_DEPTH`).
- `rd_en`  in  1  read request (mode 0) or pop acknowledge (mode 1).
- `rd_data`  out  `DATA_WIDTH`  read word.
- `rd_val`  out  1  `rd_data` is valid.
- `count`  out  `CNT_W`  current occupancy.
- `almost_full`  out  1  count ≥ `AF_LEVEL`.
- `almost_empty`  out  1  count ≤ `AE_LEVEL`.
- `overflow`  out  1  one-cycle pulse: write was attempted while full.
- `underflow`  out  1  one-cycle pulse: read was attempted while empty.

## Operation
- **Reset values.** While `reset` is high, asynchronously:
  - `wr_ptr`, `rd_ptr` and `count` = 0.
  - `rd_val`, `overflow`, `underflow` = 0; `rd_data` register = 0.
  - Resulting outputs: `wr_ready`=1, `almost_empty`=1, `almost_full`=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all data; the first cycle after release behaves as empty.
- **Write.** Accepted when `wr_en` && `wr_ready`.
  - `mem[wr_ptr]` <= `wr_data`.
  - `wr_ptr` advances, wrapping from `FIFO_DEPTH-1` to 0 by explicit compare (not by bit truncation).
  - `wr_en` while full: the word is dropped, `overflow` pulses, and state is unchanged.
- **Read.** Accepted when `rd_en` && count ≠ 0.
  - `rd_ptr` advances with the same wrap rule.
  - `rd_en` while empty: `underflow` pulses, and state is unchanged.
- **Mode 0 (`SHOW_AHEAD`=0).**
  - On an accepted read, `rd_data` <= `mem[rd_ptr]` and `rd_val` <= 1, one cycle later.
  - `rd_val` is a one-cycle pulse per accepted read.
  - `rd_data` holds its last value otherwise.
- **Mode 1 (`SHOW_AHEAD`=1).**
  - `rd_data` = `mem[rd_ptr]` combinationally; `rd_val` = (count ≠ 0).
  - `rd_en` pops the presented word.
- **Simultaneous read and write.**
  - Not empty and not full: both accepted; count unchanged.
  - Full: the read is accepted, the write is rejected with an `overflow` pulse. A read in the same cycle does not make room; no write-through.
  - Empty: the write is accepted, the read is rejected with an `underflow` pulse. No bypass: in mode 1 the word appears one cycle later.
- **Count.** count <= count + acc_wr − acc_rd. It never exceeds `FIFO_DEPTH` and never goes below 0.
- **Flags.** `wr_ready`, `almost_full` and `almost_empty` are combinational from the registered count. They carry no extra latency beyond the count update.

## Timing
- Write-to-visible latency:
  - Count and flags reflect a write in the cycle after the accepting edge.
  - Mode 1: `rd_val` rises 1 cycle after the accepting edge of the first write into an empty FIFO.
  - Mode 0: the earliest data out is 1 cycle after an accepted `rd_en`.
- Throughput is one write and one read per cycle sustained, including across pointer wrap.
- `overflow` and `underflow` are registered and appear the cycle after the offending request.
- Producers must sample `wr_ready` in the same cycle as `wr_en`. Consumers use `rd_val` (mode 0), or `rd_val` before `rd_en` (mode 1).

## Structure
- Shared package/header `fifo_pkg`:
  - width helper for `CNT_W`;
  - pointer-increment-with-wrap function;
  - read-mode constants `RD_REGISTERED`=0 and `RD_SHOW_AHEAD`=1.
- Sub-module `fifo_ring_mem`: `FIFO_DEPTH` x `DATA_WIDTH` simple dual-port array with one synchronous write port and one asynchronous read address.
- Top level `fifo_ring` holds the pointers, count, flags, error pulses and mode mux. The parameter range checks are elaboration-time assertions.

## Test plan
Configuration: `FIFO_DEPTH`=5 (non-power-of-two), `DATA_WIDTH`=8, `AF_LEVEL`=4, `AE_LEVEL`=1. Each scenario is run in both modes.
- **Reset.** Assert `reset` mid-stream with count=3 → `count`=0, `wr_ready`=1, `almost_empty`=1, `rd_val`=0 immediately (asynchronous). No stale data is read after release.
- **Fill and drain.**
  - Stimulus: write 0x11..0x55.
  - At count=4: `almost_full`=1.
  - At count=5: `wr_ready`=0.
  - A 6th write of 0x66 → `overflow` pulses once; count stays 5.
  - Drain → data 0x11..0x55 in order.
- **Empty read.** `rd_en` on an empty FIFO → `underflow` pulses once; count stays 0; `rd_val` stays 0.
- **Wrap.** Run 12 cycles of simultaneous write/read at count=2. Pointers wrap twice; count stays 2; output order exactly matches the input sequence.
- **Simultaneous at the boundaries.**
  - Full + `rd_en` + `wr_en` → one word read, write rejected, count=4.
  - Empty + both → write accepted, `underflow` pulses, count=1.
- **Mode timing.**
  - Mode 0: `rd_en` at cycle t → `rd_val` high at t+1 only.
  - Mode 1: first write at t → `rd_val`=1 and `rd_data` = written word at t+1.
